mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single instruction/data memory port between the instruction-fetch requester and the load/store (data) requester.
- Sequences each transaction through an arbitrate / wait-grant / wait-response state machine, with one transaction outstanding at a time.
- Routes the grant and read response back to the owning requester.
- Data has priority, except that a starvation counter forces instruction access after STARVE_LIMIT lost arbitrations.

Parameters:
- ADDR_W, 32, address width for both requesters and memory.
- DATA_W, 32, data width; byte-enable width is DATA_W/8.
- STARVE_LIMIT, 4, consecutive data wins against a pending fetch before fetch is forced; valid range 1..15.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- instr_req_i  in  1  fetch request; held with address until instr_gnt_o
- instr_addr_i  in  ADDR_W  fetch address
- instr_gnt_o  out  1  fetch request accepted by memory
- instr_rvalid_o  out  1  fetch read data valid
- instr_rdata_o  out  DATA_W  fetch read data
- data_req_i  in  1  load/store request; held with all fields until data_gnt_o
- data_we_i  in  1  1=store, 0=load
- data_be_i  in  DATA_W/8  byte enables
- data_addr_i  in  ADDR_W  load/store address
- data_wdata_i  in  DATA_W  store data
- data_gnt_o  out  1  data request accepted
- data_rvalid_o  out  1  response valid (loads and stores)
- data_rdata_o  out  DATA_W  load data
- mem_req_o  out  1  memory request valid
- mem_we_o  out  1  write enable (0 for fetch)
- mem_be_o  out  DATA_W/8  byte enables (all ones for fetch)
- mem_addr_o  out  ADDR_W  memory address
- mem_wdata_o  out  DATA_W  write data (0 for fetch)
- mem_instr_o  out  1  1 = transaction is an instruction fetch
- mem_gnt_i  in  1  memory accepts request this cycle
- mem_rvalid_i  in  1  memory response valid
- mem_rdata_i  in  DATA_W  memory read data

Behaviour:
- Reset: state=IDLE, owner=NONE, starve_cnt=0. All outputs are 0 in the reset cycle and until the first request.
- States:
  - IDLE: no transaction in flight.
  - WAIT_GNT: owner latched; mem_req_o=1; fields muxed combinationally from the owner's held inputs.
  - WAIT_RVALID: accepted, awaiting the response.
- Arbitration (IDLE, or the WAIT_RVALID cycle in which mem_rvalid_i=1):
  - Only one requester asserting: it wins.
  - Both asserting: data wins unless starve_cnt==STARVE_LIMIT, in which case instr wins.
  - Winner is latched as owner; next state is WAIT_GNT.
  - No requester asserting: next state is IDLE.
- starve_cnt:
  - Increments when data wins while instr_req_i=1.
  - Clears when instr wins, or when instr_req_i=0 at an arbitration point.
  - Saturates at STARVE_LIMIT.
- WAIT_GNT:
  - instr_gnt_o/data_gnt_o = mem_gnt_i, gated to the owner only, in the same cycle.
  - On mem_gnt_i, go to WAIT_RVALID.
  - Owner is locked; a higher-priority request arriving meanwhile does not preempt.
- WAIT_RVALID:
  - mem_req_o=0.
  - On mem_rvalid_i, the owner's rvalid_o is pulsed for 1 cycle, with rdata_o = mem_rdata_i in the same cycle.
  - The non-owner's rvalid_o stays 0. The non-owner's rdata_o is don't-care; drive 0.
  - Re-arbitrate in that same cycle.
  - mem_gnt_i in this state is ignored.
- Latency: request seen in IDLE at cycle N gives mem_req_o at N+1. Back-to-back transactions have one dead cycle between responses (rvalid at M, next mem_req_o at M+1).
- Spurious inputs: mem_rvalid_i in IDLE or WAIT_GNT is ignored; no response is forwarded.
- Request dropped in WAIT_GNT: if the owner deasserts req before grant (protocol violation), the arbiter still holds mem_req_o with the current fields. Verification flags this with an assertion.
- Reset mid-operation: abandons any in-flight transaction. No rvalid is forwarded for it; state returns to IDLE next cycle.
- The arbiter never issues a second mem_req_o while a transaction is outstanding.

Test Plan:
- Fetch only: instr_req_i=1, addr=0x100; mem_gnt_i at cycle 2, mem_rvalid_i with rdata=0x00500093 at cycle 4.
  - Expect mem_req_o cycles 1-2, mem_instr_o=1, mem_be_o=0xF.
  - Expect instr_gnt_o at cycle 2; instr_rvalid_o with rdata 0x00500093 at cycle 4.
- Simultaneous requests, store to 0x200 (wdata 0xDEADBEEF, be 0x3) and fetch from 0x104:
  - Store issued first with mem_we_o=1, mem_be_o=0x3.
  - Fetch issued the cycle after the store's rvalid; data_rvalid_o pulses once.
- Starvation: data_req_i and instr_req_i held high continuously, STARVE_LIMIT=4, memory grant/rvalid in 1 cycle each.
  - Expected order: D,D,D,D,I,D,D,D,D,I.
  - starve_cnt returns to 0 after each I.
- Grant stall: data load issued while mem_gnt_i is held low 5 cycles.
  - mem_addr_o stays stable and mem_req_o stays high for all 5 cycles.
  - A fetch raised mid-stall does not preempt; it is served after the load's rvalid.
- Reset mid-transaction: assert reset in WAIT_RVALID, then deliver mem_rvalid_i one cycle later.
  - All outputs are 0; no rvalid is forwarded; state is IDLE.
- Spurious mem_rvalid_i=1 in IDLE: both rvalid outputs stay 0; starve_cnt and state are unchanged.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store.
// One transaction in flight; data has priority with a starvation escape.
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                instr_req_i,
    input  logic [ADDR_W-1:0]   instr_addr_i,
    output logic                instr_gnt_o,
    output logic                instr_rvalid_o,
    output logic [DATA_W-1:0]   instr_rdata_o,
    input  logic                data_req_i,
    input  logic                data_we_i,
    input  logic [DATA_W/8-1:0] data_be_i,
    input  logic [ADDR_W-1:0]   data_addr_i,
    input  logic [DATA_W-1:0]   data_wdata_i,
    output logic                data_gnt_o,
    output logic                data_rvalid_o,
    output logic [DATA_W-1:0]   data_rdata_o,
    output logic                mem_req_o,
    output logic                mem_we_o,
    output logic [DATA_W/8-1:0] mem_be_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    output logic                mem_instr_o,
    input  logic                mem_gnt_i,
    input  logic                mem_rvalid_i,
    input  logic [DATA_W-1:0]   mem_rdata_i
);

    localparam int BE_W = DATA_W / 8;
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_GNT,
        WAIT_RVALID
    } state_e;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_INSTR,
        OWN_DATA
    } owner_e;

    state_e     state_q, state_d;
    owner_e     owner_q, owner_d;
    logic [3:0] starve_q, starve_d;

    logic arb_point;
    logic instr_wins;
    logic in_gnt;
    logic in_rsp;
    logic own_i;
    logic own_d;

    assign arb_point  = (state_q == IDLE) ||
                        ((state_q == WAIT_RVALID) && mem_rvalid_i);
    assign instr_wins = instr_req_i &&
                        (!data_req_i || (starve_q == LIMIT));

    // Next state: accept on grant, re-arbitrate when idle or on response.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        starve_d = starve_q;
        if ((state_q == WAIT_GNT) && mem_gnt_i) begin
            state_d = WAIT_RVALID;
        end
        if (arb_point) begin
            if (instr_wins) begin
                state_d  = WAIT_GNT;
                owner_d  = OWN_INSTR;
                starve_d = '0;
            end else if (data_req_i) begin
                state_d = WAIT_GNT;
                owner_d = OWN_DATA;
                if (!instr_req_i) begin
                    starve_d = '0;
                end else if (starve_q != LIMIT) begin
                    starve_d = starve_q + 4'd1;
                end
            end else begin
                state_d  = IDLE;
                owner_d  = OWN_NONE;
                starve_d = '0;
            end
        end
    end

    // State, owner and starvation counter registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            owner_q  <= OWN_NONE;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            starve_q <= starve_d;
        end
    end

    // Outputs are silenced while reset is high so an abandoned
    // transaction cannot leak a grant or response.
    assign in_gnt = !reset && (state_q == WAIT_GNT);
    assign in_rsp = !reset && (state_q == WAIT_RVALID) && mem_rvalid_i;
    assign own_i  = (owner_q == OWN_INSTR);
    assign own_d  = (owner_q == OWN_DATA);

    // Memory request fields follow the owner's held request.
    always_comb begin
        mem_req_o   = in_gnt;
        mem_instr_o = in_gnt && own_i;
        mem_we_o    = 1'b0;
        mem_be_o    = '0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (in_gnt && own_i) begin
            mem_be_o   = {BE_W{1'b1}};
            mem_addr_o = instr_addr_i;
        end else if (in_gnt && own_d) begin
            mem_we_o    = data_we_i;
            mem_be_o    = data_be_i;
            mem_addr_o  = data_addr_i;
            mem_wdata_o = data_wdata_i;
        end
    end

    // Grant and response routing back to the owner only.
    always_comb begin
        instr_gnt_o    = in_gnt && own_i && mem_gnt_i;
        data_gnt_o     = in_gnt && own_d && mem_gnt_i;
        instr_rvalid_o = in_rsp && own_i;
        data_rvalid_o  = in_rsp && own_d;
        instr_rdata_o  = instr_rvalid_o ? mem_rdata_i : '0;
        data_rdata_o   = data_rvalid_o ? mem_rdata_i : '0;
    end

    // The owner must keep requesting until its grant arrives.
    a_owner_holds_req : assert property (
        @(posedge clock) disable iff (reset)
        (state_q == WAIT_GNT) |->
            (own_i ? instr_req_i : data_req_i)
    );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus
// randomized traffic compared against a transaction-level model.
module tb_mem_port_arbiter;

    localparam int LIMIT = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        instr_req_i = 1'b0;
    logic [31:0] instr_addr_i = '0;
    logic        instr_gnt_o;
    logic        instr_rvalid_o;
    logic [31:0] instr_rdata_o;
    logic        data_req_i = 1'b0;
    logic        data_we_i = 1'b0;
    logic [3:0]  data_be_i = '0;
    logic [31:0] data_addr_i = '0;
    logic [31:0] data_wdata_i = '0;
    logic        data_gnt_o;
    logic        data_rvalid_o;
    logic [31:0] data_rdata_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_instr_o;
    logic        mem_gnt_i = 1'b0;
    logic        mem_rvalid_i = 1'b0;
    logic [31:0] mem_rdata_i = '0;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(
        .ADDR_W(32),
        .DATA_W(32),
        .STARVE_LIMIT(LIMIT)
    ) dut (
        .clock(clock),
        .reset(reset),
        .instr_req_i(instr_req_i),
        .instr_addr_i(instr_addr_i),
        .instr_gnt_o(instr_gnt_o),
        .instr_rvalid_o(instr_rvalid_o),
        .instr_rdata_o(instr_rdata_o),
        .data_req_i(data_req_i),
        .data_we_i(data_we_i),
        .data_be_i(data_be_i),
        .data_addr_i(data_addr_i),
        .data_wdata_i(data_wdata_i),
        .data_gnt_o(data_gnt_o),
        .data_rvalid_o(data_rvalid_o),
        .data_rdata_o(data_rdata_o),
        .mem_req_o(mem_req_o),
        .mem_we_o(mem_we_o),
        .mem_be_o(mem_be_o),
        .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o),
        .mem_instr_o(mem_instr_o),
        .mem_gnt_i(mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i),
        .mem_rdata_i(mem_rdata_i)
    );

    always #5 clock = ~clock;

    // Reference model: the transaction currently owning the port.
    // phase 0 = nothing pending, 1 = issued and awaiting acceptance,
    // 2 = accepted and awaiting its response.
    int          m_phase = 0;
    int          m_owner = 0;
    int          m_starve = 0;
    logic        t_instr = 1'b0;
    logic        t_we = 1'b0;
    logic [3:0]  t_be = '0;
    logic [31:0] t_addr = '0;
    logic [31:0] t_wdata = '0;

    always @(posedge clock) begin
        bit decide;
        if (reset) begin
            m_phase  = 0;
            m_owner  = 0;
            m_starve = 0;
        end else begin
            decide = (m_phase == 0) || (m_phase == 2 && mem_rvalid_i);
            if (m_phase == 1 && mem_gnt_i) m_phase = 2;
            if (decide) begin
                if (instr_req_i && (!data_req_i || m_starve == LIMIT)) begin
                    m_phase  = 1;
                    m_owner  = 1;
                    m_starve = 0;
                    t_instr  = 1'b1;
                    t_we     = 1'b0;
                    t_be     = 4'hF;
                    t_addr   = instr_addr_i;
                    t_wdata  = '0;
                end else if (data_req_i) begin
                    m_phase  = 1;
                    m_owner  = 2;
                    m_starve = instr_req_i ? ((m_starve < LIMIT) ? m_starve + 1 : LIMIT) : 0;
                    t_instr  = 1'b0;
                    t_we     = data_we_i;
                    t_be     = data_be_i;
                    t_addr   = data_addr_i;
                    t_wdata  = data_wdata_i;
                end else begin
                    m_phase  = 0;
                    m_owner  = 0;
                    m_starve = 0;
                end
            end
        end
    end

    // Every cycle, all DUT outputs against the model's prediction.
    always @(negedge clock) begin
        logic        e_req, e_rsp;
        logic [142:0] exp_v, act_v;
        e_req = !reset && m_phase == 1;
        e_rsp = !reset && m_phase == 2 && mem_rvalid_i;
        exp_v = {e_req, e_req && t_instr, e_req && t_we,
                 e_req ? t_be : 4'h0, e_req ? t_addr : 32'h0,
                 e_req ? t_wdata : 32'h0,
                 e_req && m_owner == 1 && mem_gnt_i,
                 e_req && m_owner == 2 && mem_gnt_i,
                 e_rsp && m_owner == 1, e_rsp && m_owner == 2,
                 (e_rsp && m_owner == 1) ? mem_rdata_i : 32'h0,
                 (e_rsp && m_owner == 2) ? mem_rdata_i : 32'h0};
        act_v = {mem_req_o, mem_instr_o, mem_we_o, mem_be_o, mem_addr_o,
                 mem_wdata_o, instr_gnt_o, data_gnt_o, instr_rvalid_o,
                 data_rvalid_o, instr_rdata_o, data_rdata_o};
        checks++;
        if (act_v !== exp_v) begin
            errors++;
            $display("FAIL model t=%0t: outputs=%h required=%h", $time, act_v, exp_v);
        end
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cyc();
        cyc();
        @(negedge clock);
        checks++;
        if ({mem_req_o, instr_gnt_o, data_gnt_o, instr_rvalid_o, data_rvalid_o,
             mem_addr_o, mem_be_o, mem_instr_o} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: req=%b addr=%h be=%h, required all 0",
                     mem_req_o, mem_addr_o, mem_be_o);
        end
        cyc();
        reset = 1'b0;
        @(negedge clock);
        checks++;
        if (mem_req_o !== 1'b0 || instr_rvalid_o !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: req=%b rvalid=%b, required 0 0",
                     mem_req_o, instr_rvalid_o);
        end
        cyc();
    endtask

    task automatic test_fetch_only();
        instr_req_i  = 1'b1;
        instr_addr_i = 32'h100;
        @(negedge clock);
        checks++;
        if (mem_req_o !== 1'b0) begin
            errors++;
            $display("FAIL fetch_c0_req: got %b required 0", mem_req_o);
        end
        cyc();
        @(negedge clock);
        checks++;
        if ({mem_req_o, mem_instr_o, mem_be_o, mem_addr_o, instr_gnt_o} !==
            {1'b1, 1'b1, 4'hF, 32'h100, 1'b0}) begin
            errors++;
            $display("FAIL fetch_c1_issue: req=%b instr=%b be=%h addr=%h gnt=%b required 1 1 f 100 0",
                     mem_req_o, mem_instr_o, mem_be_o, mem_addr_o, instr_gnt_o);
        end
        cyc();
        mem_gnt_i = 1'b1;
        @(negedge clock);
        checks++;
        if (instr_gnt_o !== 1'b1 || mem_req_o !== 1'b1 || data_gnt_o !== 1'b0) begin
            errors++;
            $display("FAIL fetch_c2_gnt: igt=%b req=%b dgt=%b required 1 1 0",
                     instr_gnt_o, mem_req_o, data_gnt_o);
        end
        cyc();
        mem_gnt_i   = 1'b0;
        instr_req_i = 1'b0;
        @(negedge clock);
        checks++;
        if (mem_req_o !== 1'b0 || instr_rvalid_o !== 1'b0) begin
            errors++;
            $display("FAIL fetch_c3_wait: req=%b rvalid=%b required 0 0",
                     mem_req_o, instr_rvalid_o);
        end
        cyc();
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h0050_0093;
        @(negedge clock);
        checks++;
        if (instr_rvalid_o !== 1'b1 || instr_rdata_o !== 32'h0050_0093 ||
            data_rvalid_o !== 1'b0) begin
            errors++;
            $display("FAIL fetch_c4_rsp: rvalid=%b rdata=%h drv=%b required 1 00500093 0",
                     instr_rvalid_o, instr_rdata_o, data_rvalid_o);
        end
        cyc();
        mem_rvalid_i = 1'b0;
        @(negedge clock);
        checks++;
        if (mem_req_o !== 1'b0 || instr_rvalid_o !== 1'b0) begin
            errors++;
            $display("FAIL fetch_c5_idle: req=%b rvalid=%b required 0 0",
                     mem_req_o, instr_rvalid_o);
        end
        cyc();
    endtask

    task automatic test_store_then_fetch();
        int pulses = 0;
        data_req_i   = 1'b1;
        data_we_i    = 1'b1;
        data_be_i    = 4'h3;
        data_addr_i  = 32'h200;
        data_wdata_i = 32'hDEAD_BEEF;
        instr_req_i  = 1'b1;
        instr_addr_i = 32'h104;
        mem_gnt_i    = 1'b1;
        @(negedge clock);
        pulses += int'(data_rvalid_o);
        cyc();
        @(negedge clock);
        pulses += int'(data_rvalid_o);
        checks++;
        if ({mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o, mem_instr_o, data_gnt_o} !==
            {1'b1, 1'b1, 4'h3, 32'h200, 32'hDEAD_BEEF, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL store_issue: we=%b be=%h addr=%h wdata=%h instr=%b dgt=%b required 1 3 200 deadbeef 0 1",
                     mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o, mem_instr_o, data_gnt_o);
        end
        cyc();
        data_req_i   = 1'b0;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h0000_0011;
        @(negedge clock);
        pulses += int'(data_rvalid_o);
        checks++;
        if (data_rvalid_o !== 1'b1 || instr_rvalid_o !== 1'b0 || mem_req_o !== 1'b0) begin
            errors++;
            $display("FAIL store_rsp: drv=%b irv=%b req=%b required 1 0 0",
                     data_rvalid_o, instr_rvalid_o, mem_req_o);
        end
        cyc();
        mem_rvalid_i = 1'b0;
        @(negedge clock);
        pulses += int'(data_rvalid_o);
        checks++;
        if ({mem_req_o, mem_instr_o, mem_addr_o, mem_we_o, instr_gnt_o} !==
            {1'b1, 1'b1, 32'h104, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL fetch_after_store: req=%b instr=%b addr=%h we=%b igt=%b required 1 1 104 0 1",
                     mem_req_o, mem_instr_o, mem_addr_o, mem_we_o, instr_gnt_o);
        end
        cyc();
        instr_req_i  = 1'b0;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h1234_5678;
        @(negedge clock);
        pulses += int'(data_rvalid_o);
        checks++;
        if (instr_rvalid_o !== 1'b1 || instr_rdata_o !== 32'h1234_5678) begin
            errors++;
            $display("FAIL fetch_rsp: irv=%b rdata=%h required 1 12345678",
                     instr_rvalid_o, instr_rdata_o);
        end
        cyc();
        mem_rvalid_i = 1'b0;
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL store_rvalid_pulses: got %0d required 1", pulses);
        end
        data_we_i = 1'b0;
        cyc();
    endtask

    task automatic test_starvation();
        string got = "";
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        instr_req_i  = 1'b1;
        instr_addr_i = 32'h400;
        data_req_i   = 1'b1;
        data_we_i    = 1'b0;
        data_be_i    = 4'hF;
        data_addr_i  = 32'h800;
        mem_gnt_i    = 1'b1;
        mem_rvalid_i = 1'b1;
        for (int c = 0; c < 60 && got.len() < 10; c++) begin
            @(negedge clock);
            if (mem_req_o) got = {got, mem_instr_o ? "I" : "D"};
            if (got.len() < 10) cyc();
        end
        cyc();
        instr_req_i = 1'b0;
        data_req_i  = 1'b0;
        cyc();
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        cyc();
        checks++;
        if (got != "DDDDIDDDDI") begin
            errors++;
            $display("FAIL starvation_order: got %s required DDDDIDDDDI", got);
        end
    endtask

    task automatic test_grant_stall();
        data_req_i   = 1'b1;
        data_we_i    = 1'b0;
        data_be_i    = 4'hF;
        data_addr_i  = 32'h300;
        data_wdata_i = 32'h0;
        mem_gnt_i    = 1'b0;
        cyc();
        for (int i = 1; i <= 5; i++) begin
            if (i == 2) begin
                instr_req_i  = 1'b1;
                instr_addr_i = 32'h108;
            end
            @(negedge clock);
            checks++;
            if ({mem_req_o, mem_addr_o, mem_instr_o, data_gnt_o, instr_gnt_o} !==
                {1'b1, 32'h300, 1'b0, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL stall_c%0d: req=%b addr=%h instr=%b dgt=%b igt=%b required 1 300 0 0 0",
                         i, mem_req_o, mem_addr_o, mem_instr_o, data_gnt_o, instr_gnt_o);
            end
            cyc();
        end
        mem_gnt_i = 1'b1;
        @(negedge clock);
        checks++;
        if (data_gnt_o !== 1'b1 || instr_gnt_o !== 1'b0) begin
            errors++;
            $display("FAIL stall_gnt: dgt=%b igt=%b required 1 0", data_gnt_o, instr_gnt_o);
        end
        cyc();
        data_req_i   = 1'b0;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h0000_CAFE;
        @(negedge clock);
        checks++;
        if (data_rvalid_o !== 1'b1 || data_rdata_o !== 32'h0000_CAFE || instr_rvalid_o !== 1'b0) begin
            errors++;
            $display("FAIL stall_load_rsp: drv=%b rdata=%h irv=%b required 1 0000cafe 0",
                     data_rvalid_o, data_rdata_o, instr_rvalid_o);
        end
        cyc();
        mem_rvalid_i = 1'b0;
        mem_gnt_i    = 1'b1;
        @(negedge clock);
        checks++;
        if ({mem_req_o, mem_instr_o, mem_addr_o, instr_gnt_o} !== {1'b1, 1'b1, 32'h108, 1'b1}) begin
            errors++;
            $display("FAIL stall_fetch_next: req=%b instr=%b addr=%h igt=%b required 1 1 108 1",
                     mem_req_o, mem_instr_o, mem_addr_o, instr_gnt_o);
        end
        cyc();
        instr_req_i  = 1'b0;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b1;
        cyc();
        mem_rvalid_i = 1'b0;
        cyc();
    endtask

    task automatic test_reset_mid();
        instr_req_i  = 1'b1;
        instr_addr_i = 32'h10C;
        cyc();
        mem_gnt_i = 1'b1;
        cyc();
        instr_req_i = 1'b0;
        mem_gnt_i   = 1'b0;
        reset       = 1'b1;
        @(negedge clock);
        checks++;
        if ({mem_req_o, instr_gnt_o, data_gnt_o, instr_rvalid_o, data_rvalid_o} !== 5'b0) begin
            errors++;
            $display("FAIL reset_mid_outputs: req=%b igt=%b dgt=%b irv=%b drv=%b required 0",
                     mem_req_o, instr_gnt_o, data_gnt_o, instr_rvalid_o, data_rvalid_o);
        end
        cyc();
        reset        = 1'b0;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'hBAD0_BAD0;
        @(negedge clock);
        checks++;
        if (instr_rvalid_o !== 1'b0 || data_rvalid_o !== 1'b0 || mem_req_o !== 1'b0 ||
            instr_rdata_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid_no_rsp: irv=%b drv=%b req=%b rdata=%h required 0 0 0 0",
                     instr_rvalid_o, data_rvalid_o, mem_req_o, instr_rdata_o);
        end
        cyc();
        mem_rvalid_i = 1'b0;
        @(negedge clock);
        checks++;
        if (mem_req_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_idle: req=%b required 0", mem_req_o);
        end
        cyc();
    endtask

    task automatic test_spurious_rvalid();
        for (int i = 0; i < 3; i++) begin
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = $urandom;
            @(negedge clock);
            checks++;
            if ({instr_rvalid_o, data_rvalid_o, mem_req_o} !== 3'b0) begin
                errors++;
                $display("FAIL spurious_idle: irv=%b drv=%b req=%b required 0 0 0",
                         instr_rvalid_o, data_rvalid_o, mem_req_o);
            end
            cyc();
        end
        mem_rvalid_i = 1'b0;
        cyc();
    endtask

    task automatic test_random(input int n);
        int mo = 0;
        bit igt, dgt, mreq;
        bit rvreal = 1'b0;
        bit done = 1'b0;
        bit drain;
        for (int c = 0; c < n + 300 && !done; c++) begin
            drain = (c >= n);
            @(negedge clock);
            igt  = instr_gnt_o;
            dgt  = data_gnt_o;
            mreq = mem_req_o;
            checks++;
            if (mreq && mo != 0) begin
                errors++;
                $display("FAIL overlap: mem_req_o=1 with %0d outstanding, required 0", mo);
            end
            cyc();
            if (mreq && mem_gnt_i) mo++;
            if (mem_rvalid_i && rvreal) mo--;
            if (instr_req_i && igt) instr_req_i = 1'b0;
            if (!instr_req_i && !drain && $urandom_range(0, 9) < 4) begin
                instr_req_i  = 1'b1;
                instr_addr_i = $urandom & 32'hFFFF_FFFC;
            end
            if (data_req_i && dgt) data_req_i = 1'b0;
            if (!data_req_i && !drain && $urandom_range(0, 9) < 5) begin
                data_req_i   = 1'b1;
                data_we_i    = 1'($urandom_range(0, 1));
                data_be_i    = 4'($urandom_range(1, 15));
                data_addr_i  = $urandom;
                data_wdata_i = $urandom;
            end
            mem_gnt_i    = 1'($urandom_range(0, 1));
            rvreal       = (mo > 0) && ($urandom_range(0, 1) == 1);
            mem_rvalid_i = rvreal || (mo == 0 && $urandom_range(0, 9) == 0);
            mem_rdata_i  = $urandom;
            if (drain && !instr_req_i && !data_req_i && mo == 0 && !mreq) done = 1'b1;
        end
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL random_drain: traffic still pending after budget, required drained");
        end
        cyc();
        cyc();
    endtask

    initial begin
        test_reset();
        test_fetch_only();
        test_store_then_fetch();
        test_starvation();
        test_grant_stall();
        test_reset_mid();
        test_spurious_rvalid();
        test_random(600);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
